// File: rtl/riscv_soc_top.sv
// riscv_soc_top: single-cycle RV32I core with instruction ROM and byte-writable data RAM
module riscv_rom #(
  parameter int DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [31:0]              wdata,
  input  logic [31:0]              addr,
  output logic [31:0]              data
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] rom_mem [0:DEPTH-1];
  logic        unused_addr;
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
  assign data = rom_mem[addr[AW+1:2]];
  // preload port; the SoC ties it off so the image comes from the loader
  always_ff @(posedge clk) if (we) rom_mem[waddr] <= wdata;
endmodule

module riscv_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic        we,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] regs [0:31];
  assign rd1 = ra1 == 5'd0 ? '0 : regs[ra1];
  assign rd2 = ra2 == 5'd0 ? '0 : regs[ra2];
  // single write port; x0 is never written so it always reads zero
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (we && wa != 5'd0) regs[wa] <= wd;
endmodule

module riscv_core (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  output logic        dmem_we,
  input  logic [31:0] dmem_rdata
);
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BR = 7'h63, OP_LD = 7'h03, OP_ST = 7'h23, OP_IMM = 7'h13, OP_REG = 7'h33;
  logic [31:0] pc_q, pc_d, ins, rs1_v, rs2_v, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] alu_b, alu_y, sra_y, ld_sh, ld_v, wb_v;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic        alt, taken, wb_en, unused_ld;
  assign ins = imem_data;
  assign imem_addr = pc_q;
  assign op = ins[6:0];
  assign f3 = ins[14:12];
  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'b0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  assign sra_y = $signed(rs1_v) >>> alu_b[4:0];
  assign unused_ld = ^ld_sh[31:16];
  riscv_regs regs_inst (
    .clk(clk), .rst(rst), .ra1(ins[19:15]), .ra2(ins[24:20]), .wa(ins[11:7]),
    .wd(wb_v), .we(wb_en), .rd1(rs1_v), .rd2(rs2_v)
  );
  // ALU shared by register and immediate ops; bit 30 selects SUB/SRA (SRAI for immediates)
  always_comb begin
    alu_b = op == OP_REG ? rs2_v : imm_i;
    alt = ins[30] && (op == OP_REG || f3 == 3'b101);
    case (f3)
      3'b000:  alu_y = alt ? rs1_v - alu_b : rs1_v + alu_b;
      3'b001:  alu_y = rs1_v << alu_b[4:0];
      3'b010:  alu_y = {31'b0, $signed(rs1_v) < $signed(alu_b)};
      3'b011:  alu_y = {31'b0, rs1_v < alu_b};
      3'b100:  alu_y = rs1_v ^ alu_b;
      3'b101:  alu_y = alt ? sra_y : rs1_v >> alu_b[4:0];
      3'b110:  alu_y = rs1_v | alu_b;
      default: alu_y = rs1_v & alu_b;
    endcase
  end
  // branch compare, data memory access, writeback select and next pc
  always_comb begin
    taken = f3[2:1] == 2'b00 ? (rs1_v == rs2_v) ^ f3[0] :
            f3[2:1] == 2'b10 ? ($signed(rs1_v) < $signed(rs2_v)) ^ f3[0] :
            f3[2:1] == 2'b11 ? (rs1_v < rs2_v) ^ f3[0] : 1'b0;
    dmem_addr = rs1_v + (op == OP_ST ? imm_s : imm_i);
    dmem_we = op == OP_ST && !rst;
    dmem_be = f3[1] ? 4'b1111 : f3[0] ? 4'b0011 << dmem_addr[1:0] : 4'b0001 << dmem_addr[1:0];
    dmem_wdata = f3[1] ? rs2_v : rs2_v << {dmem_addr[1:0], 3'b0};
    ld_sh = dmem_rdata >> {dmem_addr[1:0], 3'b0};
    ld_v = f3 == 3'b000 ? {{24{ld_sh[7]}}, ld_sh[7:0]} :
           f3 == 3'b001 ? {{16{ld_sh[15]}}, ld_sh[15:0]} :
           f3 == 3'b100 ? {24'b0, ld_sh[7:0]} :
           f3 == 3'b101 ? {16'b0, ld_sh[15:0]} : dmem_rdata;
    wb_v = op == OP_LUI ? imm_u :
           op == OP_AUIPC ? pc_q + imm_u :
           (op == OP_JAL || op == OP_JALR) ? pc_q + 32'd4 :
           op == OP_LD ? ld_v : alu_y;
    wb_en = !rst && (op == OP_LUI || op == OP_AUIPC || op == OP_JAL || op == OP_JALR ||
                     op == OP_LD || op == OP_IMM || op == OP_REG);
    pc_d = op == OP_JAL ? pc_q + imm_j :
           op == OP_JALR ? (rs1_v + imm_i) & ~32'd1 :
           (op == OP_BR && taken) ? pc_q + imm_b : pc_q + 32'd4;
  end
  // program counter; reset restarts fetch at word 0
  always_ff @(posedge clk) pc_q <= rst ? '0 : pc_d;
endmodule

module riscv_soc_top #(
  parameter int ROM_DEPTH = 4096,
  parameter int RAM_DEPTH = 4096
) (
  input logic clk,
  input logic rst_n
);
  localparam int RAW = $clog2(RAM_DEPTH);
  localparam int ROW = $clog2(ROM_DEPTH);
  logic [31:0]    imem_addr, imem_data, dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]     dmem_be;
  logic           dmem_we, unused_daddr;
  logic [RAW-1:0] ram_idx;
  logic [31:0]    ram_mem [0:RAM_DEPTH-1];
  assign ram_idx = dmem_addr[RAW+1:2];
  assign dmem_rdata = ram_mem[ram_idx];
  assign unused_daddr = ^{dmem_addr[31:RAW+2], dmem_addr[1:0]};
  riscv_rom #(.DEPTH(ROM_DEPTH)) rom_inst (
    .clk(clk), .we(1'b0), .waddr({ROW{1'b0}}), .wdata(32'b0), .addr(imem_addr), .data(imem_data)
  );
  riscv_core riscv_core_inst (
    .clk(clk), .rst(rst_n), .imem_addr(imem_addr), .imem_data(imem_data), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_we(dmem_we), .dmem_rdata(dmem_rdata)
  );
  // byte-lane RAM write; reset leaves contents untouched
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++) if (dmem_we && dmem_be[i]) ram_mem[ram_idx][8*i +: 8] <= dmem_wdata[8*i +: 8];
endmodule

// File: tb/tb_riscv_soc_top.sv
// tb_riscv_soc_top: directed programs with a cycle-tagged register/pc scoreboard
module tb_riscv_soc_top;
  typedef struct {
    int          cyc;
    int          r;
    logic [31:0] val;
    string       name;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  int          retired = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  exp_t        cur;
  logic [31:0] act;

  always #5 clk = ~clk;

  riscv_soc_top #(.ROM_DEPTH(4096), .RAM_DEPTH(4096)) dut (.clk(clk), .rst_n(rst_n));

  function automatic logic [31:0] ei(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                     input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] er(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                     input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] es(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                     input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] eb(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                     input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] ej(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction
  function automatic logic [31:0] eu(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  task automatic p(input int a, input logic [31:0] w);
    dut.rom_inst.rom_mem[a] = w;
  endtask

  task automatic ex(input int c, input int r, input logic [31:0] v, input string n);
    exp_t e;
    e.cyc = c;
    e.r = r;
    e.val = v;
    e.name = n;
    sb.push_back(e);
  endtask

  // assert reset, clear ROM to NOPs and expect the architectural reset state
  task automatic begin_test();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4096; i++) dut.rom_inst.rom_mem[i] = 32'h0000_0013;
    for (int r = 0; r < 32; r++) ex(0, r, 32'h0, "reset_reg");
    ex(0, 32, 32'h0, "reset_pc");
  endtask

  // second reset cycle, release, then wait (bounded) for the scoreboard to drain
  task automatic go();
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    for (int i = 0; i < 400 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL timeout: %0d expectations left, got none, required 0", sb.size());
      sb.delete();
    end
  endtask

  always @(posedge clk) retired <= rst_n ? 0 : retired + 1;

  // monitor: compare every expectation whose retire count has been reached
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= retired) begin
      cur = sb.pop_front();
      act = cur.r == 32 ? dut.riscv_core_inst.pc_q : dut.riscv_core_inst.regs_inst.regs[cur.r[4:0]];
      checks++;
      if (cur.cyc != retired || act !== cur.val) begin
        errors++;
        $display("FAIL %s r%0d at retire %0d (due %0d): got %h required %h",
                 cur.name, cur.r, retired, cur.cyc, act, cur.val);
      end
    end
  end

  initial begin
    // arithmetic, x0 protection and back-to-back dependency
    begin_test();
    p(0, ei(12'd5, 0, 3'b000, 1, 7'h13));
    p(1, ei(12'd7, 0, 3'b000, 2, 7'h13));
    p(2, er(7'h20, 2, 1, 3'b000, 3));
    p(3, ei(12'd3, 0, 3'b000, 4, 7'h13));
    p(4, er(7'h20, 0, 0, 3'b000, 4));
    p(5, ei(12'd9, 0, 3'b000, 0, 7'h13));
    p(6, ei(12'd1, 0, 3'b000, 5, 7'h13));
    p(7, er(7'h00, 5, 5, 3'b000, 6));
    ex(1, 1, 32'd5, "first_word");
    ex(2, 2, 32'd7, "addi_x2");
    ex(3, 3, 32'hFFFF_FFFE, "sub_neg");
    ex(4, 4, 32'd3, "addi_x4");
    ex(5, 4, 32'd0, "sub_zero");
    ex(6, 0, 32'd0, "x0_write");
    ex(8, 6, 32'd2, "raw_hazard");
    ex(8, 32, 32'h20, "pc_seq");
    go();
    // branches and jumps
    begin_test();
    p(0, ei(12'd5, 0, 3'b000, 1, 7'h13));
    p(1, eb(13'd8, 1, 0, 3'b001));
    p(2, ei(12'd1, 0, 3'b000, 2, 7'h13));
    p(3, ej(21'd12, 7));
    p(4, ei(12'd1, 0, 3'b000, 8, 7'h13));
    p(5, ei(12'd2, 0, 3'b000, 8, 7'h13));
    p(6, ei(12'h021, 0, 3'b000, 9, 7'h13));
    p(7, ei(12'd0, 9, 3'b000, 10, 7'h67));
    p(8, ei(12'h055, 0, 3'b000, 11, 7'h13));
    p(9, ei(12'hFFF, 0, 3'b000, 12, 7'h13));
    p(10, eb(13'd8, 0, 12, 3'b100));
    p(11, ei(12'd1, 0, 3'b000, 13, 7'h13));
    p(12, eb(13'd8, 0, 12, 3'b110));
    p(13, ei(12'd7, 0, 3'b000, 14, 7'h13));
    ex(2, 32, 32'h0C, "bne_taken_pc");
    ex(3, 7, 32'h10, "jal_link");
    ex(3, 32, 32'h18, "jal_target");
    ex(5, 10, 32'h20, "jalr_link");
    ex(5, 32, 32'h20, "jalr_lsb_clear");
    ex(6, 11, 32'h55, "jalr_resume");
    ex(6, 2, 32'h0, "bne_skipped");
    ex(6, 8, 32'h0, "jal_skipped");
    ex(8, 32, 32'h30, "blt_taken_pc");
    ex(9, 32, 32'h34, "bltu_not_taken_pc");
    ex(10, 14, 32'd7, "after_bltu");
    ex(10, 13, 32'h0, "blt_skipped");
    go();
    // loads/stores with lane selection, plus the remaining ALU forms
    begin_test();
    p(0, eu(20'h80706, 1, 7'h37));
    p(1, ei(12'h050, 1, 3'b000, 1, 7'h13));
    p(2, ei(12'h100, 0, 3'b000, 2, 7'h13));
    p(3, es(12'd0, 1, 2, 3'b010));
    p(4, ei(12'd3, 2, 3'b000, 3, 7'h03));
    p(5, ei(12'd0, 2, 3'b101, 4, 7'h03));
    p(6, ei(12'd0, 2, 3'b010, 5, 7'h03));
    p(7, es(12'd1, 0, 2, 3'b000));
    p(8, ei(12'd0, 2, 3'b010, 6, 7'h03));
    p(9, ei(12'd2, 2, 3'b001, 7, 7'h03));
    p(10, eu(20'h00001, 8, 7'h17));
    p(11, ei(12'd0, 3, 3'b010, 9, 7'h13));
    p(12, ei(12'h404, 3, 3'b101, 10, 7'h13));
    p(13, ei(12'h01C, 3, 3'b101, 11, 7'h13));
    p(14, er(7'h00, 3, 0, 3'b011, 12));
    p(15, er(7'h00, 1, 3, 3'b111, 13));
    p(16, er(7'h00, 11, 9, 3'b001, 14));
    p(17, er(7'h20, 11, 3, 3'b101, 15));
    ex(2, 1, 32'h8070_6050, "lui_addi");
    ex(5, 3, 32'hFFFF_FF80, "lb_0x103");
    ex(6, 4, 32'h0000_6050, "lhu_0x100");
    ex(7, 5, 32'h8070_6050, "lw_0x100");
    ex(9, 6, 32'h8070_0050, "sb_lane1");
    ex(10, 7, 32'hFFFF_8070, "lh_0x102");
    ex(11, 8, 32'h0000_1028, "auipc");
    ex(12, 9, 32'd1, "slti");
    ex(13, 10, 32'hFFFF_FFF8, "srai");
    ex(14, 11, 32'h0000_000F, "srli");
    ex(15, 12, 32'd1, "sltu");
    ex(16, 13, 32'h8070_6000, "and");
    ex(17, 14, 32'h0000_8000, "sll");
    ex(18, 15, 32'hFFFF_FFFF, "sra");
    go();
    // reset after a busy program, then NOPs only advance the pc
    begin_test();
    ex(4, 32, 32'h10, "nop_pc");
    ex(4, 1, 32'h0, "nop_no_write");
    go();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
